// File: rtl/wb_ram_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter in front of one single-port RAM slave.
// Optional slave watchdog enabled by defining WB_RAM_ARBITER_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_ram_arbiter_2m #(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [1:0]           grant_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_M0   = 2'b01,
        ST_M1   = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_owner;
    logic   w_last_owner_nxt;
    logic   w_timeout;

    function automatic state_t arbitrate(input logic req0, input logic req1, input logic last);
        if (req0 && req1) return last ? ST_M0 : ST_M1;
        if (req0)         return ST_M0;
        if (req1)         return ST_M1;
        return ST_IDLE;
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Release re-arbitrates in the same edge so the other master sees no idle bubble.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            ST_IDLE: w_state_nxt = arbitrate(m0_cyc_i, m1_cyc_i, r_last_owner);
            ST_M0: begin
                if (!m0_cyc_i) begin
                    w_last_owner_nxt = 1'b0;
                    w_state_nxt      = arbitrate(m0_cyc_i, m1_cyc_i, 1'b0);
                end
            end
            ST_M1: begin
                if (!m1_cyc_i) begin
                    w_last_owner_nxt = 1'b1;
                    w_state_nxt      = arbitrate(m0_cyc_i, m1_cyc_i, 1'b1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Slave port and return path follow the grant register.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            ST_M0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~w_timeout;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | w_timeout;
            end
            ST_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~w_timeout;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | w_timeout;
            end
            default: ;
        endcase
    end

    assign grant_o = r_state;

`ifdef WB_RAM_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wdog;
    logic             r_timeout;
    logic             w_pending;

    // Strobe outstanding at the slave with no termination this cycle.
    assign w_pending = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_timeout) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (w_pending) begin
            if (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_wdog    <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_wdog <= r_wdog + CNT_W'(1);
            end
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_arbiter_2m.sv
// Directed bench for wb_ram_arbiter_2m with a 1-cycle-ack behavioural RAM slave.
`timescale 1ns/1ps
module tb_wb_ram_arbiter_2m;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter_2m #(.ADR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant)
    );

    // RAM slave: single-cycle registered ack, byte-lane writes.
    logic [31:0] mem [0:255];
    logic        ram_ack;
    logic [31:0] ram_dat;
    logic        ram_en    = 1'b1;
    logic        force_ack = 1'b0;
    logic        force_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ram_ack <= 1'b0;
        end else if (s_cyc && s_stb && !ram_ack && ram_en) begin
            ram_ack <= 1'b1;
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
            end
            ram_dat <= mem[s_adr[9:2]];
        end else begin
            ram_ack <= 1'b0;
        end
    end

    assign s_ack  = ram_ack | force_ack;
    assign s_err  = force_err;
    assign s_rdat = ram_dat;

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = sel;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = sel;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic keep,
                        output logic [31:0] rd, output logic [3:0] ssel);
        bit got = 0;
        rd = '0;
        ssel = '0;
        drive(m, 1'b1, 1'b1, we, adr, dat, sel);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1;
                rd = (m == 0) ? m0_rdat : m1_rdat;
                ssel = s_sel;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL xfer_ack m%0d adr=%h: got no ack, required ack within 20 cycles", m, adr);
        end
        @(posedge clk); #1;
        drive(m, keep, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
        force_ack = 1'b0; force_err = 1'b0; ram_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF);
        drive(1, 1, 1, 1, 32'h80, 32'h12345678, 4'hF);
        force_ack = 1'b1; force_err = 1'b1;
        #2;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b need 00", grant); end
        checks++;
        if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat} !== 39'd0) begin
            errors++; $display("FAIL reset_slave_port: got cyc%b stb%b we%b sel%h adr%h dat%h need all 0",
                               s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat);
        end
        checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err, m0_rdat, m1_rdat} !== 68'd0) begin
            errors++; $display("FAIL reset_master_ret: got ack%b%b err%b%b need 0", m0_ack, m1_ack, m0_err, m1_err);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL reset_hold_grant: got %b need 00", grant); end
        do_reset();
    endtask

    task automatic test_read_m0();
        logic [31:0] rd;
        logic [3:0]  ss;
        do_reset();
        xfer(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, rd, ss);
        @(posedge clk); #1;
        drive(0, 1, 1, 0, 32'h40, '0, 4'hF);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL read_c0_grant: got %b need 00", grant); end
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || s_stb !== 1'b1 || s_adr !== 32'h40 || m0_ack !== 1'b0) begin
            errors++; $display("FAIL read_c1: got grant%b stb%b adr%h ack%b need 01 1 40 0", grant, s_stb, s_adr, m0_ack);
        end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_c2_m0: got ack%b dat%h need 1 deadbeef", m0_ack, m0_rdat);
        end
        checks++;
        if (m1_ack !== 1'b0 || m1_rdat !== 32'h0) begin
            errors++; $display("FAIL read_c2_m1: got ack%b dat%h need 0 0", m1_ack, m1_rdat);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL read_release: got %b need 00", grant); end
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(0, 1, 0, 0, '0, '0, '0);
        drive(1, 1, 0, 0, '0, '0, '0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL rr_first: got %b need 01", grant); end
        @(posedge clk); #1;
        m0_cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL rr_hold: got %b need 01", grant); end
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL rr_handover: got %b need 10", grant); end
        @(posedge clk); #1;
        m1_cyc = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle1: got %b need 00", grant); end
        @(posedge clk); #1;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL rr_after_m1: got %b need 01", grant); end
        @(posedge clk); #1;
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL rr_after_m0: got %b need 10", grant); end
        @(posedge clk); #1;
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_locked_burst();
        logic [31:0] rd;
        logic [3:0]  ss;
        logic [31:0] exp_d [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_reset();
        drive(1, 1, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            xfer(1, 1'b1, 32'(4 * k), exp_d[k], 4'hF, (k < 2), rd, ss);
            checks++;
            if (grant !== 2'b10) begin errors++; $display("FAIL burst_lock%0d: got %b need 10", k, grant); end
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL burst_drop_cycle: got %b need 10", grant); end
        @(posedge clk); #1;
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL burst_handover: got %b need 01", grant); end
        for (int k = 0; k < 3; k++) begin
            xfer(0, 1'b0, 32'(4 * k), '0, 4'hF, (k < 2), rd, ss);
            checks++;
            if (rd !== exp_d[k]) begin errors++; $display("FAIL burst_readback%0d: got %h need %h", k, rd, exp_d[k]); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        logic [3:0]  ss;
        do_reset();
        xfer(0, 1'b1, 32'h14, 32'h0, 4'hF, 1'b0, rd, ss);
        xfer(0, 1'b1, 32'h14, 32'h0000AB00, 4'b0010, 1'b0, rd, ss);
        checks++;
        if (ss !== 4'b0010) begin errors++; $display("FAIL byte_sel: got %b need 0010", ss); end
        xfer(0, 1'b0, 32'h14, '0, 4'hF, 1'b0, rd, ss);
        checks++;
        if (rd !== 32'h0000AB00) begin errors++; $display("FAIL byte_zero_word: got %h need 0000ab00", rd); end
        xfer(0, 1'b1, 32'h18, 32'h11223344, 4'hF, 1'b0, rd, ss);
        xfer(0, 1'b1, 32'h18, 32'hFFFFABFF, 4'b0010, 1'b0, rd, ss);
        xfer(0, 1'b0, 32'h18, '0, 4'hF, 1'b0, rd, ss);
        checks++;
        if (rd !== 32'h1122AB44) begin errors++; $display("FAIL byte_merge: got %h need 1122ab44", rd); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(0, 1, 1, 0, 32'h40, '0, 4'hF);
        drive(1, 1, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEADBEEF || grant !== 2'b01) begin
            errors++; $display("FAIL b2b_late_ack: got ack%b dat%h grant%b need 1 deadbeef 01", m0_ack, m0_rdat, grant);
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || m0_ack !== 1'b0) begin
            errors++; $display("FAIL b2b_no_bubble: got grant%b m0_ack%b need 10 0", grant, m0_ack);
        end
        @(posedge clk); #1;
        drive(1, 0, 0, 0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_spurious_err();
        do_reset();
        force_ack = 1'b1; force_err = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            errors++; $display("FAIL spurious_idle: got %b need 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        @(posedge clk); #1;
        force_ack = 1'b0; force_err = 1'b0; ram_en = 1'b0;
        drive(1, 1, 1, 0, 32'h40, '0, 4'hF);
        @(posedge clk); #1;
        force_err = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_err !== 1'b1 || m0_err !== 1'b0) begin
            errors++; $display("FAIL err_route: got m1_err%b m0_err%b need 1 0", m1_err, m0_err);
        end
        @(posedge clk); #1;
        force_err = 1'b0; ram_en = 1'b1;
        drive(1, 0, 0, 0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        do_reset();
        ram_en = 1'b0;
        drive(0, 1, 1, 0, 32'h40, '0, 4'hF);
        @(negedge clk);
`ifdef WB_RAM_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (m0_err !== (k == 5) || s_stb !== (k != 5)) begin
                errors++; $display("FAIL timeout_c%0d: got err%b stb%b need %b %b", k, m0_err, s_stb, (k == 5), (k != 5));
            end
        end
`else
        begin
            int err_seen = 0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (m0_err || m1_err) err_seen++;
            end
            checks++;
            if (err_seen != 0 || s_stb !== 1'b1) begin
                errors++; $display("FAIL no_timeout: got %0d err cycles stb%b need 0 1", err_seen, s_stb);
            end
        end
`endif
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        ram_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [3:0]  ss;
        do_reset();
        xfer(0, 1'b0, 32'h40, '0, 4'hF, 1'b0, rd, ss);
        drive(1, 1, 1, 0, 32'h40, '0, 4'hF);
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_stb !== 1'b1) begin
            errors++; $display("FAIL rstmid_owned: got grant%b stb%b need 10 1", grant, s_stb);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop: got grant%b cyc%b stb%b need 00 0 0", grant, s_cyc, s_stb);
        end
        drive(1, 0, 0, 0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_ack: got m1_ack%b m0_ack%b need 0 0", m1_ack, m0_ack);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1, 0, 0, '0, '0, '0);
        drive(1, 1, 0, 0, '0, '0, '0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL rstmid_priority: got %b need 01", grant); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_read_m0();
        test_round_robin();
        test_locked_burst();
        test_byte_write();
        test_back_to_back();
        test_spurious_err();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/wb_ram_arbiter_2m.md
Name: wb_ram_arbiter_2m

Overview:
Two-master Wishbone arbiter sharing one single-port synchronous 32-bit RAM slave, e.g. the CPU instruction and data buses in the OR10 simulation top level. It registers a grant, muxes the owner's request onto the slave port and routes ack/err/data back only to the owner. Arbitration is round-robin. The bus is locked to the owner for as long as that master holds cyc.

Parameters:
- ADR_WIDTH, 32: address bus width, passed through unchanged.
- TIMEOUT_CYCLES, 16: watchdog limit in cycles; used only with the optional feature; must be >= 2.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- m0_adr_i  in  ADR_WIDTH  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_we_i, m0_cyc_i, m0_stb_i  in  1 each  master 0 controls.
- m0_dat_o  out  32  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  terminations to master 0.
- m1_*  same set as m0_*, for master 1.
- s_adr_o  out  ADR_WIDTH  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o, s_cyc_o, s_stb_o  out  1 each  slave controls.
- s_dat_i  in  32  slave read data.
- s_ack_i, s_err_i  in  1 each  slave terminations.
- grant_o  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = none.

Behaviour:
- Registers:
  - grant[1:0], one-hot or zero.
  - last_owner, 1 bit.
  - Watchdog counter (optional feature only).
- Reset, immediate and asynchronous:
  - grant = 00, last_owner = 1 (so m0 wins the first tie).
  - Counter = 0.
  - Outputs then follow combinationally: s_cyc_o = s_stb_o = s_we_o = 0, s_sel_o = 0, s_adr_o = 0, s_dat_o = 0, all m*_ack_o/err_o = 0, m*_dat_o = 0, grant_o = 00.
- Request: a master requests when its cyc_i = 1 (stb not required).
- State IDLE (grant = 00), at each clock edge:
  - Only mX requesting: grant mX.
  - Both requesting: grant the master that is not last_owner.
  - Neither requesting: stay IDLE.
- State OWNED (grant = mX):
  - Slave port = mX's adr/dat/sel/we/cyc/stb, combinational from the grant register.
  - mX_ack_o = s_ack_i, mX_err_o = s_err_i, mX_dat_o = s_dat_i.
  - The non-owner sees ack = err = 0 and dat = 0.
- Release: at the edge where the owner's cyc_i = 0:
  - last_owner <= X.
  - Re-arbitrate in the same edge using the IDLE rules with the updated last_owner, so the other master gets the bus without an idle bubble; otherwise go to IDLE.
- An owner that keeps cyc high across several stb/ack pairs keeps the bus (locked transfers, back-to-back bursts).
- Latency:
  - Request at cycle n, IDLE: grant at edge n+1; slave sees stb during cycle n+1.
  - 1-cycle RAM ack arrives at edge n+2.
  - Cycle n+2: ack is still visible to the master; the RAM drops ack itself, so the arbiter adds no handshake logic.
- Slave ack/err while grant = 00 (spurious): ignored, not routed.
- Owner drops cyc in the same cycle ack arrives: ack is still routed that cycle; release happens at that edge.
- Reset mid-transaction: grant cleared and slave cyc/stb dropped immediately; an in-flight ack is discarded.
- Pure mux plus grant FSM: no data buffering, no write reordering.

Optional Feature:
- Macro: WB_RAM_ARBITER_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle the owner has cyc & stb = 1 and s_ack_i = s_err_i = 0.
  - Counter clears on s_ack_i, on s_err_i, on release, or when stb = 0.
  - When the counter reaches TIMEOUT_CYCLES-1, the next cycle the arbiter forces owner err_o = 1 and s_stb_o = 0 for one cycle, then clears the counter.
  - This protects against a hung or unmapped slave.
- Undefined: no counter; a transfer without ack waits forever.

Test Plan:
- m0 read, m1 idle; RAM word 0x10 = 0xDEADBEEF; m0 adr 0x40 sel F raised at cycle 0 -> grant_o = 01 at cycle 1, m0_ack_o = 1 with m0_dat_o = 0xDEADBEEF at cycle 2, m1_ack_o stays 0.
- Both cyc raised at cycle 0 after reset -> m0 granted first; when m0 drops cyc, grant_o goes 01 -> 10 at the same edge; repeat -> m1 is then preferred over m0.
- m1 holds cyc for 3 writes (0x11111111, 0x22222222, 0x33333333 to adr 0, 4, 8) while m0 requests -> m0 not granted until m1 drops cyc; RAM readback matches.
- Byte write through m0, sel = 0010, dat 0x0000AB00 on a word holding 0 -> readback 0x0000AB00; s_sel_o observed = 0010.
- wb_rst_i pulsed mid-transfer (after grant, before ack) -> s_cyc_o = 0 and grant_o = 00 within the same cycle, no ack delivered to the master; next request arbitrates from reset priority (m0 first).
- With WB_RAM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, slave ack tied to 0 -> owner err_o = 1 exactly 4 cycles after stb first seen at the slave; without the macro -> no err ever.
